// File: rtl/vdma_write_triple_buffer_ctl_pkg.sv
// vdma_write_triple_buffer_ctl_pkg: slot encodings, reset permutation and per-cycle event kinds
package vdma_write_triple_buffer_ctl_pkg;
    typedef logic [1:0] slot_t;
    localparam slot_t SLOT0 = 2'd0;
    localparam slot_t SLOT1 = 2'd1;
    localparam slot_t SLOT2 = 2'd2;
    localparam slot_t RST_W = SLOT0;
    localparam slot_t RST_L = SLOT1;
    localparam slot_t RST_R = SLOT2;
    typedef enum logic [2:0] {
        EV_NONE,
        EV_ACCEPT_RUN,
        EV_ACCEPT_IDLE,
        EV_FALL,
        EV_READ
    } wr_event_t;
endpackage

// File: rtl/vdma_write_triple_buffer_ctl.sv
// vdma_write_triple_buffer_ctl: rotates three frame buffers between a VDMA write core and a reader
module vdma_write_triple_buffer_ctl
    import vdma_write_triple_buffer_ctl_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_LEN_WIDTH  = 8,
    parameter int STRIDE_WIDTH    = 14,
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12,
    parameter int INDEX_WIDTH     = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_enable,
    input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr0,
    input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr1,
    input  logic [AXI4_ADDR_WIDTH-1:0] cfg_addr2,
    input  logic [STRIDE_WIDTH-1:0]    cfg_stride,
    input  logic [H_WIDTH-1:0]         cfg_width,
    input  logic [V_WIDTH-1:0]         cfg_height,
    input  logic [AXI4_LEN_WIDTH-1:0]  cfg_awlen,
    output logic                       ctl_enable,
    output logic                       ctl_update,
    input  logic                       ctl_busy,
    input  logic [INDEX_WIDTH-1:0]     ctl_index,
    output logic [AXI4_ADDR_WIDTH-1:0] param_addr,
    output logic [STRIDE_WIDTH-1:0]    param_stride,
    output logic [H_WIDTH-1:0]         param_width,
    output logic [V_WIDTH-1:0]         param_height,
    output logic [AXI4_LEN_WIDTH-1:0]  param_awlen,
    input  logic                       rd_req,
    output logic                       rd_ack,
    output logic                       rd_new,
    output logic [AXI4_ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]                 status_w,
    output logic [1:0]                 status_l,
    output logic [1:0]                 status_r,
    output logic                       status_fresh
);
    slot_t                  r_w, r_l, r_r;
    logic                   r_fresh, r_busy_q, r_rd_ack, r_rd_new;
    logic [INDEX_WIDTH-1:0] r_index_q;
    logic                   w_idx_chg, w_fall;
    wr_event_t              w_evt;

    function automatic logic [AXI4_ADDR_WIDTH-1:0] slot_addr(input slot_t s);
        return s == SLOT0 ? cfg_addr0 : s == SLOT1 ? cfg_addr1 : cfg_addr2;
    endfunction

    assign w_idx_chg = ctl_index != r_index_q;
    assign w_fall    = r_busy_q && !ctl_busy;

    // Writer events always win; a pending read retries next cycle since rd_req is a held level.
    always_comb begin
        w_evt = w_idx_chg ? (r_busy_q ? EV_ACCEPT_RUN : EV_ACCEPT_IDLE) :
                w_fall    ? EV_FALL :
                (rd_req && !r_rd_ack) ? EV_READ : EV_NONE;
    end

    // Withholding enable while slots move keeps the core from latching a stale address.
    assign ctl_enable   = aresetn && cfg_enable && !w_fall && (w_evt != EV_READ);
    assign ctl_update   = 1'b1;
    assign param_addr   = slot_addr((ctl_busy || !r_fresh) ? r_l : r_w);
    assign param_stride = cfg_stride;
    assign param_width  = cfg_width;
    assign param_height = cfg_height;
    assign param_awlen  = cfg_awlen;
    assign rd_ack       = r_rd_ack;
    assign rd_new       = r_rd_new;
    assign rd_addr      = slot_addr(r_r);
    assign status_w     = r_w;
    assign status_l     = r_l;
    assign status_r     = r_r;
    assign status_fresh = r_fresh;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_w       <= RST_W;
            r_l       <= RST_L;
            r_r       <= RST_R;
            r_fresh   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_index_q <= '0;
            r_rd_ack  <= 1'b0;
            r_rd_new  <= 1'b0;
        end else begin
            r_busy_q  <= ctl_busy;
            r_index_q <= ctl_index;
            r_rd_ack  <= w_evt == EV_READ;
            r_rd_new  <= (w_evt == EV_READ) && r_fresh;
            case (w_evt)
                EV_ACCEPT_RUN, EV_FALL: begin
                    r_w     <= r_l;
                    r_l     <= r_w;
                    r_fresh <= 1'b1;
                end
                EV_ACCEPT_IDLE: begin
                    if (!r_fresh) begin
                        r_w <= r_l;
                        r_l <= r_w;
                    end
                end
                EV_READ: begin
                    if (r_fresh) begin
                        r_r     <= r_l;
                        r_l     <= r_r;
                        r_fresh <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vdma_write_triple_buffer_ctl.sv
// tb_vdma_write_triple_buffer_ctl: directed scenarios plus randomized traffic from a write-core
// and reader model, checked every cycle against a role-table model of the triple buffer
module tb_vdma_write_triple_buffer_ctl;
    logic        aclk = 0;
    logic        aresetn = 0;
    logic        cfg_enable = 0;
    logic [31:0] cfg_addr0 = 32'h1000_0000;
    logic [31:0] cfg_addr1 = 32'h1010_0000;
    logic [31:0] cfg_addr2 = 32'h1020_0000;
    logic [13:0] cfg_stride = 14'h0a00;
    logic [11:0] cfg_width = 12'd640;
    logic [11:0] cfg_height = 12'd480;
    logic [7:0]  cfg_awlen = 8'd15;
    logic        ctl_enable, ctl_update;
    logic        ctl_busy = 0;
    logic [7:0]  ctl_index = 0;
    logic [31:0] param_addr;
    logic [13:0] param_stride;
    logic [11:0] param_width, param_height;
    logic [7:0]  param_awlen;
    logic        rd_req = 0;
    logic        rd_ack, rd_new;
    logic [31:0] rd_addr;
    logic [1:0]  status_w, status_l, status_r;
    logic        status_fresh;

    vdma_write_triple_buffer_ctl dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable),
        .cfg_addr0(cfg_addr0), .cfg_addr1(cfg_addr1), .cfg_addr2(cfg_addr2),
        .cfg_stride(cfg_stride), .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_awlen(cfg_awlen),
        .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_busy(ctl_busy), .ctl_index(ctl_index),
        .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
        .param_height(param_height), .param_awlen(param_awlen),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_new(rd_new), .rd_addr(rd_addr),
        .status_w(status_w), .status_l(status_l), .status_r(status_r), .status_fresh(status_fresh)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input int s);
        return s == 0 ? cfg_addr0 : s == 1 ? cfg_addr1 : cfg_addr2;
    endfunction

    // Model: role_slot[0/1/2] is the buffer held as writer / latest / reader.
    int   role_slot [3] = '{0, 1, 2};
    logic m_fresh = 0, m_pb = 0, m_ack = 0, m_new = 0;
    logic [7:0] m_pi = 0;

    function automatic void swap_roles(input int i, input int j);
        int t = role_slot[i];
        role_slot[i] = role_slot[j];
        role_slot[j] = t;
    endfunction

    // Write-core and reader model state shared with the stimulus process.
    logic        core_busy = 0;
    int          core_cnt = 0;
    logic [7:0]  core_idx = 0;
    logic [31:0] core_addr = 0;
    int          dir_len = 6;
    logic        rand_mode = 0;
    logic        s_en = 0, s_ack = 0;
    logic [31:0] s_param = 0;

    always @(negedge aclk) begin : compare
        logic ic, fl, rsw, nn;
        ic  = ctl_index != m_pi;
        fl  = m_pb && !ctl_busy;
        rsw = rd_req && !m_ack && !ic && !fl;
        chk("ctl_enable", ctl_enable, aresetn && cfg_enable && !fl && !rsw);
        chk("ctl_update", ctl_update, 1'b1);
        chk("param_addr", param_addr, addr_of((ctl_busy || !m_fresh) ? role_slot[1] : role_slot[0]));
        chk("param_geom", {param_stride, param_width, param_height, param_awlen},
            {cfg_stride, cfg_width, cfg_height, cfg_awlen});
        chk("rd_addr", rd_addr, addr_of(role_slot[2]));
        chk("rd_ack", rd_ack, m_ack);
        chk("rd_new", rd_new, m_new);
        chk("status_w", status_w, role_slot[0]);
        chk("status_l", status_l, role_slot[1]);
        chk("status_r", status_r, role_slot[2]);
        chk("status_fresh", status_fresh, m_fresh);
        chk("permutation", (status_w != status_l) && (status_l != status_r) && (status_w != status_r)
            && status_w < 3 && status_l < 3 && status_r < 3, 1'b1);
        if (core_busy) chk("core_writes_reader_slot", core_addr == rd_addr, 1'b0);
        s_en = ctl_enable;
        s_param = param_addr;
        s_ack = rd_ack;
        if (!aresetn) begin
            role_slot = '{0, 1, 2};
            {m_fresh, m_pb, m_ack, m_new, m_pi} = '0;
        end else begin
            nn = rsw && m_fresh;
            if (ic || fl) begin
                // m_pb is set for both a back-to-back accept and a fall: a frame just completed.
                if (m_pb || !m_fresh) swap_roles(0, 1);
                if (m_pb) m_fresh = 1;
            end else if (nn) begin
                swap_roles(2, 1);
                m_fresh = 0;
            end
            m_ack = rsw;
            m_new = nn;
            m_pb = ctl_busy;
            m_pi = ctl_index;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
        if (!aresetn) begin
            core_busy = 0;
            core_cnt = 0;
            core_idx = 0;
        end else if (core_busy && core_cnt > 1) begin
            core_cnt--;
        end else if (s_en) begin
            core_addr = s_param;
            core_busy = 1;
            core_cnt = rand_mode ? int'($urandom_range(2, 6)) : dir_len;
            core_idx++;
        end else begin
            core_busy = 0;
        end
        ctl_busy = core_busy;
        ctl_index = core_idx;
        if (rand_mode) begin
            if (rd_req && s_ack) rd_req = 0;
            else if (!rd_req && $urandom_range(0, 3) == 0) rd_req = 1;
        end
    endtask

    task automatic wait_idx(input logic [7:0] n);
        for (int i = 0; i < 100 && core_idx != n; i++) step();
        chk("wait_idx", core_idx, n);
    endtask

    initial begin
        cfg_enable = 1;
        repeat (3) step();
        @(negedge aclk);
        chk("rst_ctl_enable", ctl_enable, 1'b0);
        chk("rst_rd_addr", rd_addr, 32'h1020_0000);
        chk("rst_param_addr", param_addr, 32'h1010_0000);
        step();
        aresetn = 1;
        wait_idx(1);
        step();
        @(negedge aclk);
        chk("first_accept_addr", core_addr, 32'h1010_0000);
        chk("idle_w", status_w, 2'd1);
        chk("idle_l", status_l, 2'd0);
        chk("idle_fresh", status_fresh, 1'b0);
        wait_idx(2);
        step();
        @(negedge aclk);
        chk("run_w", status_w, 2'd0);
        chk("run_l", status_l, 2'd1);
        chk("run_fresh", status_fresh, 1'b1);
        chk("run_param_addr", param_addr, 32'h1010_0000);
        step();
        rd_req = 1;
        @(negedge aclk);
        chk("fetch_enable_low", ctl_enable, 1'b0);
        step();
        rd_req = 0;
        @(negedge aclk);
        chk("fetch_ack", rd_ack, 1'b1);
        chk("fetch_new", rd_new, 1'b1);
        chk("fetch_r", status_r, 2'd1);
        chk("fetch_l", status_l, 2'd2);
        chk("fetch_rd_addr", rd_addr, 32'h1010_0000);
        chk("fetch_enable_back", ctl_enable, 1'b1);
        step();
        rd_req = 1;
        step();
        rd_req = 0;
        @(negedge aclk);
        chk("stale_ack", rd_ack, 1'b1);
        chk("stale_new", rd_new, 1'b0);
        chk("stale_rd_addr", rd_addr, 32'h1010_0000);
        chk("stale_r", status_r, 2'd1);
        step();
        cfg_enable = 0;
        for (int i = 0; i < 100 && core_busy; i++) step();
        @(negedge aclk);
        chk("fall_enable_low", ctl_enable, 1'b0);
        step();
        cfg_enable = 1;
        @(negedge aclk);
        chk("fall_fresh", status_fresh, 1'b1);
        chk("fall_w", status_w, 2'd0);
        chk("fall_l", status_l, 2'd2);
        chk("reenable_param_addr", param_addr, 32'h1000_0000);
        step();
        step();
        @(negedge aclk);
        chk("reenable_core_addr", core_addr, 32'h1000_0000);
        chk("preserved_l", status_l, 2'd2);
        chk("preserved_fresh", status_fresh, 1'b1);
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 59) == 0) cfg_enable = ~cfg_enable;
            if (i == 1500 || i == 3200) aresetn = 0;
            if (i == 1502 || i == 3202) aresetn = 1;
        end
        @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
